// File: rtl/trace_uart_scheduler_if.sv
// rtl/trace_uart_scheduler_if.sv - trace/console/UART bundle for trace_uart_scheduler
//   trace_data[35:0], trace_valid, trap : core trace capture and trap notification
//   con_data[7:0], con_valid, con_ready : console byte handshake
//   tx_data[7:0], tx_valid, tx_ready    : byte stream to the UART transmitter
//   ovf, drain_done, drop_count[15:0]   : status
//   modport slave  : scheduler side
//   modport master : core / console / transmitter side
interface trace_uart_scheduler_if;
  logic [35:0] trace_data;
  logic        trace_valid;
  logic        trap;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        ovf;
  logic        drain_done;
  logic [15:0] drop_count;

  modport slave (
    input  trace_data, trace_valid, trap, con_data, con_valid, tx_ready,
    output con_ready, tx_data, tx_valid, ovf, drain_done, drop_count
  );

  modport master (
    output trace_data, trace_valid, trap, con_data, con_valid, tx_ready,
    input  con_ready, tx_data, tx_valid, ovf, drain_done, drop_count
  );
endinterface

// File: rtl/trace_uart_scheduler.sv
// rtl/trace_uart_scheduler.sv - round-robin sharing of one UART byte stream between console and trace frames
//   external_clock  : single rising-edge clock
//   external_resetn : asynchronous active-low reset
//   bus (slave)     : trace capture, console handshake, tx byte stream, ovf/drain_done/drop_count
//   TRACE_DROP_CNT_EN : when defined, drop_count is a saturating dropped-word counter; else tied to 0
module trace_uart_scheduler #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                    external_clock,
  input  logic                    external_resetn,
  trace_uart_scheduler_if.slave   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic RR_CON   = 1'b0;
  localparam logic RR_TRACE = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_CON, S_HDR, S_DATA} state_e;

  state_e       state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic         rr_q, rr_d;
  logic [7:0]   con_byte_q, con_byte_d;
  logic [35:0]  frame_q, frame_d;
  logic         trap_seen_q, ovf_q, drain_done_q;

  logic [35:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]  count_q, count_d;

  logic fifo_empty, fifo_full, push, drop, pop;
  logic pick_con, con_ready_w, tx_valid_w;
  logic [7:0] tx_data_w;

  // Full comes from the registered count, so a same-cycle pop never frees a slot for a push.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign push = bus.trace_valid && !fifo_full && !trap_seen_q;
  assign drop = bus.trace_valid &&  fifo_full && !trap_seen_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge external_clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.trace_data;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_d        = rr_q;
    con_byte_d  = con_byte_q;
    frame_d     = frame_q;
    pop         = 1'b0;
    pick_con    = 1'b0;
    con_ready_w = 1'b0;
    tx_valid_w  = 1'b0;
    tx_data_w   = 8'h00;
    case (state_q)
      S_IDLE: begin
        // With both pending, serve whichever was not served last.
        pick_con = bus.con_valid && (fifo_empty || rr_q == RR_TRACE);
        if (pick_con) begin
          con_ready_w = 1'b1;
          con_byte_d  = bus.con_data;
          state_d     = S_CON;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          frame_d = mem_q[rd_ptr_q];
          state_d = S_HDR;
        end
      end
      S_CON: begin
        tx_valid_w = 1'b1;
        tx_data_w  = con_byte_q;
        if (bus.tx_ready) begin
          state_d = S_IDLE;
          rr_d    = RR_CON;
        end
      end
      S_HDR: begin
        tx_valid_w = 1'b1;
        tx_data_w  = SYNC_BYTE;
        if (bus.tx_ready) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        tx_valid_w = 1'b1;
        case (idx_q)
          3'd0:    tx_data_w = {4'h0, frame_q[35:32]};
          3'd1:    tx_data_w = frame_q[31:24];
          3'd2:    tx_data_w = frame_q[23:16];
          3'd3:    tx_data_w = frame_q[15:8];
          default: tx_data_w = frame_q[7:0];
        endcase
        if (bus.tx_ready) begin
          if (idx_q == 3'd4) begin
            state_d = S_IDLE;
            rr_d    = RR_TRACE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge external_clock or negedge external_resetn) begin
    if (!external_resetn) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      rr_q         <= RR_CON;
      con_byte_q   <= 8'h00;
      frame_q      <= 36'h0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      trap_seen_q  <= 1'b0;
      ovf_q        <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rr_q        <= rr_d;
      con_byte_q  <= con_byte_d;
      frame_q     <= frame_d;
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      trap_seen_q <= trap_seen_q | bus.trap;
      ovf_q       <= ovf_q | drop;
      drain_done_q <= drain_done_q | (trap_seen_q && fifo_empty && state_q == S_IDLE);
    end
  end

`ifdef TRACE_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  always_ff @(posedge external_clock or negedge external_resetn) begin
    if (!external_resetn) begin
      drop_cnt_q <= 16'h0;
    end else if (drop && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
  assign bus.drop_count = drop_cnt_q;
`else
  assign bus.drop_count = 16'h0;
`endif

  assign bus.con_ready  = con_ready_w;
  assign bus.tx_valid   = tx_valid_w;
  assign bus.tx_data    = tx_data_w;
  assign bus.ovf        = ovf_q;
  assign bus.drain_done = drain_done_q;

endmodule

// File: tb/tb_trace_uart_scheduler.sv
// tb/tb_trace_uart_scheduler.sv - table-driven scoreboard bench for trace_uart_scheduler
module tb_trace_uart_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  trace_uart_scheduler_if bus();

  trace_uart_scheduler #(.FIFO_DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
    .external_clock  (clk),
    .external_resetn (rst_n),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] word;
    logic [7:0]  exp [6];
    bit          tog;
  } vec_t;

  vec_t vecs [5];

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb [$];
  logic [7:0] con_q [$];
  bit   tog_mode = 1'b0;
  logic tx_ready_cfg = 1'b0;
  logic stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic [7:0] e_byte;

`ifdef TRACE_DROP_CNT_EN
  localparam logic [15:0] EXP_DROPS = 16'd3;
`else
  localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_frame(input logic [35:0] w);
    sb.push_back(8'hA5);
    sb.push_back({4'h0, w[35:32]});
    sb.push_back(w[31:24]);
    sb.push_back(w[23:16]);
    sb.push_back(w[15:8]);
    sb.push_back(w[7:0]);
  endfunction

  // Input drivers: update just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (tog_mode) bus.tx_ready = ~bus.tx_ready;
    else          bus.tx_ready = tx_ready_cfg;
    bus.con_valid = (con_q.size() > 0);
    bus.con_data  = (con_q.size() > 0) ? con_q[0] : 8'h00;
  end

  // Output monitor on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        chk("hold_valid", 64'(bus.tx_valid), 64'd1);
        chk("hold_data", 64'(bus.tx_data), 64'(stall_data));
      end
      if (bus.con_valid && bus.con_ready && con_q.size() > 0) void'(con_q.pop_front());
      if (bus.tx_valid && bus.tx_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got %02h expected none", bus.tx_data);
        end else begin
          e_byte = sb.pop_front();
          chk("tx_byte", 64'(bus.tx_data), 64'(e_byte));
        end
      end
      stall_prev <= bus.tx_valid && !bus.tx_ready;
      stall_data <= bus.tx_data;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    sb.delete();
    con_q.delete();
    bus.trace_valid = 1'b0;
    bus.trap = 1'b0;
    tog_mode = 1'b0;
    tx_ready_cfg = rdy;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sync();
  endtask

  task automatic send_word(input logic [35:0] w);
    bus.trace_data  = w;
    bus.trace_valid = 1'b1;
    sync();
    bus.trace_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, 64'(sb.size()), 64'd0);
    sync();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [35:0] w;
    int i;

    vecs[0].word = 36'h9_1234_5678; vecs[0].exp = '{8'hA5, 8'h09, 8'h12, 8'h34, 8'h56, 8'h78}; vecs[0].tog = 1'b0;
    vecs[1].word = 36'hF_FFFF_FFFF; vecs[1].exp = '{8'hA5, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF}; vecs[1].tog = 1'b0;
    vecs[2].word = 36'h0_0000_0000; vecs[2].exp = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[2].tog = 1'b1;
    vecs[3].word = 36'hA_5A5A_5A5A; vecs[3].exp = '{8'hA5, 8'h0A, 8'h5A, 8'h5A, 8'h5A, 8'h5A}; vecs[3].tog = 1'b0;
    vecs[4].word = 36'h3_C0DE_0001; vecs[4].exp = '{8'hA5, 8'h03, 8'hC0, 8'hDE, 8'h00, 8'h01}; vecs[4].tog = 1'b1;

    bus.trace_data  = 36'h0;
    bus.trace_valid = 1'b0;
    bus.trap        = 1'b0;

    // Reset state
    do_reset(1'b1);
    @(negedge clk);
    chk("rst_tx_valid",   64'(bus.tx_valid), 64'd0);
    chk("rst_tx_data",    64'(bus.tx_data), 64'd0);
    chk("rst_con_ready",  64'(bus.con_ready), 64'd0);
    chk("rst_ovf",        64'(bus.ovf), 64'd0);
    chk("rst_drain_done", 64'(bus.drain_done), 64'd0);
    chk("rst_drop_count", 64'(bus.drop_count), 64'd0);
    sync();

    // Latency: trace_valid in cycle N -> header valid in cycle N+2
    push_frame(36'h1_0203_0405);
    bus.trace_data  = 36'h1_0203_0405;
    bus.trace_valid = 1'b1;
    @(negedge clk);
    chk("lat_n0_valid", 64'(bus.tx_valid), 64'd0);
    sync();
    bus.trace_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1_valid", 64'(bus.tx_valid), 64'd0);
    @(negedge clk);
    chk("lat_n2_valid", 64'(bus.tx_valid), 64'd1);
    chk("lat_n2_data",  64'(bus.tx_data), 64'hA5);
    wait_drain("lat_drain", 100);

    // Table of single frames, some with tx_ready toggling
    for (int k = 0; k < 5; k++) begin
      tog_mode = vecs[k].tog;
      for (int j = 0; j < 6; j++) sb.push_back(vecs[k].exp[j]);
      send_word(vecs[k].word);
      wait_drain("frame_drain", 200);
      chk("frame_drain_done", 64'(bus.drain_done), 64'd0);
      chk("frame_ovf",        64'(bus.ovf), 64'd0);
      tog_mode = 1'b0;
      sync();
    end

    // Console held while frames are queued: strict alternation, frames unsplit
    do_reset(1'b0);
    send_word(36'h1_1111_1111);
    send_word(36'h2_2222_2222);
    send_word(36'h3_3333_3333);
    con_q.push_back(8'hC0);
    con_q.push_back(8'hC1);
    con_q.push_back(8'hC2);
    push_frame(36'h1_1111_1111); sb.push_back(8'hC0);
    push_frame(36'h2_2222_2222); sb.push_back(8'hC1);
    push_frame(36'h3_3333_3333); sb.push_back(8'hC2);
    repeat (2) sync();
    tx_ready_cfg = 1'b1;
    wait_drain("alt_drain", 400);

    // Overflow: FSM parked on a stalled console byte, FIFO_DEPTH+3 words pushed
    do_reset(1'b0);
    con_q.push_back(8'h3C);
    sb.push_back(8'h3C);
    repeat (3) sync();
    chk("ovf_con_accepted", 64'(con_q.size()), 64'd0);
    for (int k = 0; k < 16; k++) begin
      w = {k[3:0], 32'hC0DE_0000 | 32'(k)};
      push_frame(w);
      bus.trace_data  = w;
      bus.trace_valid = 1'b1;
      sync();
    end
    bus.trace_valid = 1'b0;
    @(negedge clk);
    chk("ovf_before_drop", 64'(bus.ovf), 64'd0);
    sync();
    for (int k = 0; k < 3; k++) send_word(36'hE_EEEE_EE00 | 36'(k));
    @(negedge clk);
    chk("ovf_after_drop", 64'(bus.ovf), 64'd1);
    chk("drop_count",     64'(bus.drop_count), 64'(EXP_DROPS));
    sync();
    tx_ready_cfg = 1'b1;
    wait_drain("ovf_drain", 1000);
    repeat (20) sync();
    chk("ovf_no_extra_frames", 64'(bus.tx_valid), 64'd0);

    // Trap: two queued words plus the trap-cycle word are drained, then drain_done
    do_reset(1'b0);
    con_q.push_back(8'h77);
    sb.push_back(8'h77);
    repeat (3) sync();
    send_word(36'h4_0000_0001);
    send_word(36'h4_0000_0002);
    bus.trace_data  = 36'h4_0000_0003;
    bus.trace_valid = 1'b1;
    bus.trap        = 1'b1;
    sync();
    bus.trap        = 1'b0;
    bus.trace_data  = 36'h4_DEAD_BEEF;
    repeat (4) sync();
    bus.trace_valid = 1'b0;
    push_frame(36'h4_0000_0001);
    push_frame(36'h4_0000_0002);
    push_frame(36'h4_0000_0003);
    @(negedge clk);
    chk("trap_drain_early", 64'(bus.drain_done), 64'd0);
    sync();
    tx_ready_cfg = 1'b1;
    wait_drain("trap_drain", 400);
    repeat (5) sync();
    chk("trap_drain_done", 64'(bus.drain_done), 64'd1);
    chk("trap_ovf",        64'(bus.ovf), 64'd0);
    chk("trap_drop_count", 64'(bus.drop_count), 64'd0);
    send_word(36'h4_FFFF_0000);
    con_q.push_back(8'h5E);
    sb.push_back(8'h5E);
    wait_drain("trap_console_after", 100);
    repeat (10) sync();
    chk("trap_drain_sticky", 64'(bus.drain_done), 64'd1);

    // Reset mid-frame at DATA idx 2
    do_reset(1'b1);
    push_frame(36'hB_CAFE_F00D);
    send_word(36'hB_CAFE_F00D);
    i = 0;
    @(negedge clk);
    while (!(bus.tx_valid && bus.tx_data == 8'hFE) && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("midframe_reached", 64'(i < 50), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midframe_rst_valid", 64'(bus.tx_valid), 64'd0);
    chk("midframe_rst_data",  64'(bus.tx_data), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) sync();
    chk("midframe_no_resume", 64'(bus.tx_valid), 64'd0);
    push_frame(36'h7_0102_0304);
    send_word(36'h7_0102_0304);
    wait_drain("midframe_after", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
